// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow bypass the iteration.
module div_unit #(
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [4:0]        op_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [4:0]        rd_i,
   input  logic              flush_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [DATA_W-1:0] result_o,
   output logic [4:0]        rd_o,
   output logic              busy_o
);

   localparam int CNT_W = $clog2(DATA_W);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt;
   logic [DATA_W-1:0]   quo, rem, divisor;
   logic                neg_q, neg_r, sel_rem;

   logic                accept, is_div_op, is_signed, a_neg, b_neg;
   logic                div_zero, overflow, special;
   logic [DATA_W-1:0]   a_abs, b_abs;
   logic [DATA_W:0]     shifted, trial;
   logic [DATA_W-1:0]   quo_nxt, rem_nxt;

   // Flush blocks acceptance so a killed cycle never loads new operands.
   assign accept    = valid_i && ready_o && !flush_i;
   assign is_div_op = (op_i[4:2] == 3'b101);
   assign is_signed = ~op_i[0];
   assign a_neg     = is_signed & a_i[DATA_W-1];
   assign b_neg     = is_signed & b_i[DATA_W-1];
   assign a_abs     = a_neg ? -a_i : a_i;
   assign b_abs     = b_neg ? -b_i : b_i;
   assign div_zero  = (b_i == '0);
   assign overflow  = is_signed && (a_i == {1'b1, {(DATA_W-1){1'b0}}}) && (b_i == '1);
   assign special   = div_zero || overflow;

   // Full-width partial remainder keeps divisors with the MSB set exact.
   assign shifted = {rem, quo[DATA_W-1]};
   assign trial   = shifted - {1'b0, divisor};
   assign rem_nxt = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
   assign quo_nxt = {quo[DATA_W-2:0], ~trial[DATA_W]};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
      state_nxt = state;
      case (state)
         IDLE: if (accept && is_div_op) state_nxt = special ? DONE : CALC;
         CALC: if (cnt == '0)           state_nxt = DONE;
         DONE: if (ready_i)             state_nxt = IDLE;
         default:                       state_nxt = IDLE;
      endcase
      if (flush_i) state_nxt = IDLE;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt      <= '0;
         quo      <= '0;
         rem      <= '0;
         divisor  <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         sel_rem  <= 1'b0;
         result_o <= '0;
         rd_o     <= '0;
      end else if (state == IDLE && accept && is_div_op) begin
         quo     <= a_abs;
         divisor <= b_abs;
         rem     <= '0;
         cnt     <= CNT_W'(DATA_W - 1);
         neg_q   <= a_neg ^ b_neg;
         neg_r   <= a_neg;
         sel_rem <= op_i[1];
         rd_o    <= rd_i;
         // Overflow quotient equals the dividend (most negative value).
         if (div_zero)      result_o <= op_i[1] ? a_i : '1;
         else if (overflow) result_o <= op_i[1] ? '0  : a_i;
      end else if (state == CALC && !flush_i) begin
         quo <= quo_nxt;
         rem <= rem_nxt;
         cnt <= cnt - 1'b1;
         if (cnt == '0)
            result_o <= sel_rem ? (neg_r ? -rem_nxt : rem_nxt)
                                : (neg_q ? -quo_nxt : quo_nxt);
      end
   end

   assign ready_o = (state == IDLE);
   assign valid_o = (state == DONE);
   assign busy_o  = (state != IDLE);

endmodule
